// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: datapath widths, response ids and ALU opcodes.
package alu_arbiter_pkg;

    localparam int unsigned ALU_XLEN  = 32;
    localparam int unsigned ALU_OPS_W = 4;

    // Response id encodes the source port of the request.
    localparam logic REQ_EXE = 1'b0;
    localparam logic REQ_CSR = 1'b1;

    typedef enum logic [ALU_OPS_W-1:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpXor  = 4'd4,
        OpSll  = 4'd5,
        OpSrl  = 4'd6,
        OpSra  = 4'd7,
        OpSlt  = 4'd8,
        OpSltu = 4'd9,
        OpGe   = 4'd10,
        OpGeu  = 4'd11,
        OpEq   = 4'd12,
        OpNeq  = 4'd13
    } alu_op_e;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU; compare ops return 0/1, undefined opcodes return zero.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned XLEN   = ALU_XLEN,
    parameter int unsigned ALUOPS = ALU_OPS_W
) (
    input  logic [ALUOPS-1:0] i_op,
    input  logic [XLEN-1:0]   i_data_1,
    input  logic [XLEN-1:0]   i_data_2,
    output logic [XLEN-1:0]   o_result
);

    logic [4:0] shamt;
    logic       flag;

    assign shamt = i_data_2[4:0];

    always_comb begin
        o_result = '0;
        flag     = 1'b0;
        case (i_op)
            OpAdd:   o_result = i_data_1 + i_data_2;
            OpSub:   o_result = i_data_1 - i_data_2;
            OpAnd:   o_result = i_data_1 & i_data_2;
            OpOr:    o_result = i_data_1 | i_data_2;
            OpXor:   o_result = i_data_1 ^ i_data_2;
            OpSll:   o_result = i_data_1 << shamt;
            OpSrl:   o_result = i_data_1 >> shamt;
            OpSra:   o_result = $signed(i_data_1) >>> shamt;
            OpSlt:   flag = $signed(i_data_1) < $signed(i_data_2);
            OpSltu:  flag = i_data_1 < i_data_2;
            OpGe:    flag = $signed(i_data_1) >= $signed(i_data_2);
            OpGeu:   flag = i_data_1 >= i_data_2;
            OpEq:    flag = i_data_1 == i_data_2;
            OpNeq:   flag = i_data_1 != i_data_2;
            default: o_result = '0;
        endcase
        if (flag) begin
            o_result = {{(XLEN-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one ALU between execute (port 0) and CSR RMW (port 1),
// with a single registered, tagged response slot.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned XLEN          = ALU_XLEN,
    parameter int unsigned ALUOPS        = ALU_OPS_W,
    parameter int unsigned PRIORITY_MODE = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [ALUOPS-1:0] i_req0_op,
    input  logic [XLEN-1:0]   i_req0_data_1,
    input  logic [XLEN-1:0]   i_req0_data_2,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [ALUOPS-1:0] i_req1_op,
    input  logic [XLEN-1:0]   i_req1_data_1,
    input  logic [XLEN-1:0]   i_req1_data_2,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_id,
    output logic [XLEN-1:0]   o_rsp_result
);

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [XLEN-1:0]   rsp_result_q, rsp_result_d;
    logic              last_q, last_d;

    logic              free;
    logic              grant0, grant1;
    logic              fire0, fire1;
    logic [ALUOPS-1:0] alu_op;
    logic [XLEN-1:0]   alu_data_1, alu_data_2, alu_result;

    assign free = !rsp_valid_q || i_rsp_ready;

    always_comb begin
        grant0 = i_req0_valid;
        grant1 = i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
            // Tie: fixed mode always favours execute, round-robin favours the other port.
            grant0 = (PRIORITY_MODE == 1) || (last_q == REQ_CSR);
            grant1 = !grant0;
        end
    end

    assign o_req0_ready = grant0 && free && !i_rst;
    assign o_req1_ready = grant1 && free && !i_rst;
    assign fire0        = i_req0_valid && o_req0_ready;
    assign fire1        = i_req1_valid && o_req1_ready;

    assign alu_op     = grant1 ? i_req1_op     : i_req0_op;
    assign alu_data_1 = grant1 ? i_req1_data_1 : i_req0_data_1;
    assign alu_data_2 = grant1 ? i_req1_data_2 : i_req0_data_2;

    alu #(
        .XLEN   (XLEN),
        .ALUOPS (ALUOPS)
    ) u_alu (
        .i_op     (alu_op),
        .i_data_1 (alu_data_1),
        .i_data_2 (alu_data_2),
        .o_result (alu_result)
    );

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        last_d       = last_q;
        if (fire0 || fire1) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = fire1 ? REQ_CSR : REQ_EXE;
            rsp_result_d = alu_result;
            last_d       = fire1 ? REQ_CSR : REQ_EXE;
        end else if (i_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= REQ_EXE;
            rsp_result_q <= '0;
            last_q       <= REQ_CSR;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            last_q       <= last_d;
        end
    end

    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Drives a round-robin instance [0] and a fixed-priority instance [1] with shared stimulus.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, rsp_ready;
    logic [3:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;

    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        rsp_valid [2];
    logic        rsp_id [2];
    logic [31:0] rsp_result [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state per instance
    bit          m_valid [2];
    bit          m_id [2];
    bit [31:0]   m_result [2];
    bit          m_last [2];

    always #5 clk = ~clk;

    alu_arbiter #(.PRIORITY_MODE(0)) u_rr (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(rdy0[0]), .i_req0_op(op0),
        .i_req0_data_1(a0), .i_req0_data_2(b0),
        .i_req1_valid(v1), .o_req1_ready(rdy1[0]), .i_req1_op(op1),
        .i_req1_data_1(a1), .i_req1_data_2(b1),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready),
        .o_rsp_id(rsp_id[0]), .o_rsp_result(rsp_result[0])
    );

    alu_arbiter #(.PRIORITY_MODE(1)) u_fp (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(rdy0[1]), .i_req0_op(op0),
        .i_req0_data_1(a0), .i_req0_data_2(b0),
        .i_req1_valid(v1), .o_req1_ready(rdy1[1]), .i_req1_op(op1),
        .i_req1_data_1(a1), .i_req1_data_2(b1),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready),
        .o_rsp_id(rsp_id[1]), .o_rsp_result(rsp_result[1])
    );

    function automatic bit [31:0] ref_alu(input bit [3:0] op, input bit [31:0] a, input bit [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        int     sh = int'(b % 32);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return 32'(longint'(a) * (longint'(1) << sh));
            4'd6:    return 32'(longint'(a) / (longint'(1) << sh));
            4'd7: begin
                // Floor division gives arithmetic right shift for negatives too.
                longint d = longint'(1) << sh;
                longint q = sa / d;
                if (sa < 0 && (sa % d) != 0) q = q - 1;
                return 32'(q);
            end
            4'd8:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return (sa >= sb) ? 32'd1 : 32'd0;
            4'd11:   return (a >= b) ? 32'd1 : 32'd0;
            4'd12:   return (a == b) ? 32'd1 : 32'd0;
            4'd13:   return (a != b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // -1 = nobody, else the port that wins this cycle for the given mode.
    function automatic int winner(input int mode, input bit last);
        if (v0 && v1) return (mode == 1) ? 0 : (last ? 0 : 1);
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        v0 = 0; v1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0; m_id[m] = 0; m_result[m] = 0; m_last[m] = 1;
        end
    endtask

    task automatic test_reset();
        rsp_ready = 1;
        rst = 1; v0 = 1; op0 = OpAdd; a0 = 1; b0 = 2;
        #1;
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (rdy0[m] !== 1'b0) begin
                n_fail++; $display("FAIL reset_ready[%0d]: got %b want 0", m, rdy0[m]);
            end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if ({rsp_valid[m], rsp_id[m], rsp_result[m]} !== 34'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got v=%b id=%b r=%h want 0/0/0",
                         m, rsp_valid[m], rsp_id[m], rsp_result[m]);
            end
        end
        rst = 0; idle_inputs();
    endtask

    task automatic test_single();
        do_reset();
        v0 = 1; op0 = OpAdd; a0 = 10; b0 = 5;
        #1;
        n_checks++;
        if ({rdy0[0], rdy1[0]} !== 2'b10) begin
            n_fail++; $display("FAIL single_ready: got %b%b want 10", rdy0[0], rdy1[0]);
        end
        tick();
        v0 = 0;
        n_checks++;
        if ({rsp_valid[0], rsp_id[0], rsp_result[0]} !== {1'b1, 1'b0, 32'd15}) begin
            n_fail++; $display("FAIL single_rsp: got v=%b id=%b r=%h want 1/0/0000000f",
                               rsp_valid[0], rsp_id[0], rsp_result[0]);
        end
        tick();
        n_checks++;
        if (rsp_valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL single_drop: got %b want 0", rsp_valid[0]);
        end
    endtask

    task automatic test_tie_rr();
        do_reset();
        v0 = 1; op0 = OpSub; a0 = 15; b0 = 20;
        v1 = 1; op1 = OpOr;  a1 = 32'hF0F0_F0F0; b1 = 32'h0FF0_0FF0;
        #1;
        n_checks++;
        if ({rdy0[0], rdy1[0]} !== 2'b10) begin
            n_fail++; $display("FAIL tie_ready: got %b%b want 10", rdy0[0], rdy1[0]);
        end
        tick();
        v0 = 0;
        n_checks++;
        if ({rsp_id[0], rsp_result[0]} !== {1'b0, 32'hFFFF_FFFB}) begin
            n_fail++; $display("FAIL tie_first: got id=%b r=%h want 0/fffffffb", rsp_id[0], rsp_result[0]);
        end
        tick();
        v1 = 0;
        n_checks++;
        if ({rsp_valid[0], rsp_id[0], rsp_result[0]} !== {1'b1, 1'b1, 32'hFFF0_FFF0}) begin
            n_fail++; $display("FAIL tie_second: got v=%b id=%b r=%h want 1/1/fff0fff0",
                               rsp_valid[0], rsp_id[0], rsp_result[0]);
        end
    endtask

    task automatic test_backpressure();
        v0 = 1; op0 = OpXor; a0 = 32'hAAAA_AAAA; b0 = 32'h5555_5555;
        tick();
        v0 = 0; rsp_ready = 0;
        v1 = 1; op1 = OpSra; a1 = -32'sd64; b1 = 2;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if ({rdy0[0], rdy1[0], rsp_valid[0], rsp_id[0], rsp_result[0]} !==
                {2'b00, 1'b1, 1'b0, 32'hFFFF_FFFF}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got rdy=%b%b v=%b id=%b r=%h want 00/1/0/ffffffff",
                         i, rdy0[0], rdy1[0], rsp_valid[0], rsp_id[0], rsp_result[0]);
            end
            tick();
        end
        rsp_ready = 1;
        #1;
        n_checks++;
        if (rdy1[0] !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready: got %b want 1", rdy1[0]);
        end
        tick();
        v1 = 0;
        n_checks++;
        if ({rsp_valid[0], rsp_id[0], rsp_result[0]} !== {1'b1, 1'b1, 32'hFFFF_FFF0}) begin
            n_fail++; $display("FAIL bp_sra: got v=%b id=%b r=%h want 1/1/fffffff0",
                               rsp_valid[0], rsp_id[0], rsp_result[0]);
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        v0 = 1; op0 = OpAdd; a0 = 7; b0 = 3;
        v1 = 1; op1 = OpSlt; a1 = 5; b1 = 10;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if ({rdy0[1], rdy1[1]} !== 2'b10) begin
                n_fail++; $display("FAIL fp_ready[%0d]: got %b%b want 10", i, rdy0[1], rdy1[1]);
            end
            tick();
            n_checks++;
            if (rsp_id[1] !== 1'b0) begin
                n_fail++; $display("FAIL fp_id[%0d]: got %b want 0", i, rsp_id[1]);
            end
            n_checks++;
            if (rsp_id[0] !== i[0]) begin
                n_fail++; $display("FAIL rr_alternate[%0d]: got %b want %b", i, rsp_id[0], i[0]);
            end
        end
        v0 = 0;
        #1;
        n_checks++;
        if (rdy1[1] !== 1'b1) begin
            n_fail++; $display("FAIL fp_port1_ready: got %b want 1", rdy1[1]);
        end
        tick();
        v1 = 0;
        n_checks++;
        if ({rsp_id[1], rsp_result[1]} !== {1'b1, 32'd1}) begin
            n_fail++; $display("FAIL fp_slt: got id=%b r=%h want 1/00000001", rsp_id[1], rsp_result[1]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        v0 = 1; op0 = OpSll; a0 = 1; b0 = 3;
        tick();
        v0 = 0; rsp_ready = 0;
        n_checks++;
        if ({rsp_valid[0], rsp_result[0]} !== {1'b1, 32'd8}) begin
            n_fail++; $display("FAIL mid_sll: got v=%b r=%h want 1/00000008", rsp_valid[0], rsp_result[0]);
        end
        tick();
        rst = 1;
        tick();
        rst = 0;
        n_checks++;
        if ({rsp_valid[0], rsp_result[0]} !== 33'd0) begin
            n_fail++; $display("FAIL mid_reset: got v=%b r=%h want 0/0", rsp_valid[0], rsp_result[0]);
        end
        rsp_ready = 1;
        v0 = 1; op0 = OpAdd; a0 = 1; b0 = 1;
        v1 = 1; op1 = OpAdd; a1 = 2; b1 = 2;
        #1;
        n_checks++;
        if ({rdy0[0], rdy1[0]} !== 2'b10) begin
            n_fail++; $display("FAIL mid_tie: got %b%b want 10", rdy0[0], rdy1[0]);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1;
        v0 = 1; op0 = OpEq; a0 = 100; b0 = 100;
        tick();
        n_checks++;
        if ({rsp_valid[0], rsp_result[0]} !== {1'b1, 32'd1}) begin
            n_fail++; $display("FAIL b2b_eq: got v=%b r=%h want 1/00000001", rsp_valid[0], rsp_result[0]);
        end
        op0 = OpNeq; a0 = 10; b0 = 20;
        #1;
        n_checks++;
        if (rdy0[0] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready: got %b want 1", rdy0[0]);
        end
        tick();
        v0 = 0;
        n_checks++;
        if ({rsp_valid[0], rsp_result[0]} !== {1'b1, 32'd1}) begin
            n_fail++; $display("FAIL b2b_neq: got v=%b r=%h want 1/00000001", rsp_valid[0], rsp_result[0]);
        end
    endtask

    task automatic test_random();
        int w [2];
        bit exp0, exp1, free;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            v0 = ($urandom_range(0, 9) < 6); v1 = ($urandom_range(0, 9) < 6);
            op0 = 4'($urandom_range(0, 13)); op1 = 4'($urandom_range(0, 13));
            a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            a1 = $urandom; b1 = $urandom;
            rsp_ready = ($urandom_range(0, 9) < 7);
            #1;
            for (int m = 0; m < 2; m++) begin
                free = !m_valid[m] || rsp_ready;
                w[m] = free ? winner(m, m_last[m]) : -1;
                exp0 = (w[m] == 0); exp1 = (w[m] == 1);
                n_checks++;
                if ({rdy0[m], rdy1[m]} !== {exp0, exp1}) begin
                    n_fail++; $display("FAIL rand_ready[%0d] cyc %0d: got %b%b want %b%b",
                                       m, cyc, rdy0[m], rdy1[m], exp0, exp1);
                end
            end
            for (int m = 0; m < 2; m++) begin
                if (w[m] == 0) begin
                    m_valid[m] = 1; m_id[m] = 0; m_last[m] = 0; m_result[m] = ref_alu(op0, a0, b0);
                end else if (w[m] == 1) begin
                    m_valid[m] = 1; m_id[m] = 1; m_last[m] = 1; m_result[m] = ref_alu(op1, a1, b1);
                end else if (rsp_ready) begin
                    m_valid[m] = 0;
                end
            end
            tick();
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if ({rsp_valid[m], rsp_id[m], rsp_result[m]} !== {m_valid[m], m_id[m], m_result[m]}) begin
                    n_fail++;
                    $display("FAIL rand_rsp[%0d] cyc %0d: got v=%b id=%b r=%h want %b/%b/%h",
                             m, cyc, rsp_valid[m], rsp_id[m], rsp_result[m],
                             m_valid[m], m_id[m], m_result[m]);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rsp_ready = 1;
        rst = 1;
        tick();
        tick();
        test_reset();
        test_single();
        test_tie_rr();
        test_backpressure();
        test_fixed_priority();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational `alu` between two requesters: port 0 is the execute stage and port 1 is the CSR read-modify-write unit.
- Arbitrates between the two valid/ready request channels.
- Drives the winning operands into one internal `alu` instance.
- Registers the result onto one tagged response channel with backpressure.
- Sits between decode/execute and CSR logic and the ALU datapath.

Parameters:
XLEN, `XLEN (32), operand/result width.
ALUOPS, `ALUOPS, width of the ALU opcode field.
PRIORITY_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with port 0 winning.

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  synchronous, active-high reset
i_req0_valid  in  1  execute request valid
o_req0_ready  out  1  execute request accepted this cycle when valid&ready
i_req0_op  in  ALUOPS  execute opcode (`ADD..`NEQ)
i_req0_data_1  in  XLEN  execute operand 1
i_req0_data_2  in  XLEN  execute operand 2
i_req1_valid  in  1  CSR request valid
o_req1_ready  out  1  CSR request accept
i_req1_op  in  ALUOPS  CSR opcode
i_req1_data_1  in  XLEN  CSR operand 1
i_req1_data_2  in  XLEN  CSR operand 2
o_rsp_valid  out  1  response register holds a result
i_rsp_ready  in  1  consumer accepts the response
o_rsp_id  out  1  source port of the response (0 = execute, 1 = CSR)
o_rsp_result  out  XLEN  ALU result

Behaviour:
- Reset (i_rst=1 at an edge):
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0.
  - RR pointer set so that port 0 wins the first tie.
  - Any in-flight response is discarded.
- Slot free: free = !o_rsp_valid | i_rsp_ready. This is combinational, so ready paths depend on i_rsp_ready.
- Grant (combinational, only among valid ports):
  - Exactly one port valid: that port is granted.
  - Both valid, PRIORITY_MODE=0: grant the port not served last.
  - Both valid, PRIORITY_MODE=1: grant port 0.
  - No port valid: no grant.
- Ready: o_reqN_ready = grantN & free. At most one ready is high per cycle, and ready never rises for a non-valid port.
- Fire: fireN = i_reqN_valid & o_reqN_ready. On fireN at the clock edge:
  - o_rsp_valid<=1.
  - o_rsp_id<=N.
  - o_rsp_result<=alu(i_reqN_op, i_reqN_data_1, i_reqN_data_2).
  - RR pointer records N as last served.
- No fire and i_rsp_ready=1: o_rsp_valid<=0. Result and id hold their last value.
- No fire and i_rsp_ready=0: everything holds.
- Latency and throughput:
  - Request accepted at edge k gives a response visible after edge k, i.e. 1 cycle latency.
  - Throughput is 1 op per cycle while i_rsp_ready=1.
  - With both ports continuously valid in round-robin mode, ids alternate 0,1,0,1.
- Backpressure: while o_rsp_valid=1 and i_rsp_ready=0, both readies are 0 and o_rsp_* are stable.
- Requester rule: valid, op and data stay stable until fire. The arbiter does not latch a request before fire.
- ALU semantics:
  - Arithmetic wraps modulo 2^XLEN.
  - Shift amount is data_2[4:0].
  - SLT and SRA are signed.
  - SLT/GE/EQ/NEQ return 32'd1 or 32'd0.
  - Opcodes are not decoded here; an undefined opcode returns whatever `alu` produces.
- Reset in the same cycle as a valid request: the request is not accepted and o_reqN_ready is forced to 0 while i_rst=1.

Decomposition:
- Shared header.vh holds `XLEN, `ALUOPS and the opcode defines (already present).
- Add REQ_EXE=1'b0 and REQ_CSR=1'b1 to header.vh for the response id.
- One sub-module: the existing `alu`, instantiated once with a muxed op and operands.
- Arbitration logic, RR pointer and response register stay inline.

Test Plan:
1. Single request: port0 ADD 10,5, rsp_ready=1 -> next cycle o_rsp_valid=1, id=0, result=15; valid drops the following cycle.
2. Tie after reset, RR mode: port0 SUB 15,20 and port1 OR F0F0F0F0,0FF00FF0 both valid -> cycle 1 gives id0 result FFFFFFFB; cycle 2 gives id1 result FFF0FFF0; o_req1_ready=0 in cycle 0.
3. Backpressure: rsp_ready=0 after port0 XOR AAAAAAAA,55555555 -> result FFFFFFFF held 5 cycles; both readies 0. Raise rsp_ready -> a pending port1 SRA -64,2 fires the same cycle; next result is FFFFFFF0 with id1.
4. Fixed priority (PRIORITY_MODE=1): both ports valid for 4 cycles -> four id0 responses and port1 never ready. Drop port0 -> port1 SLT 5,10 returns 1.
5. Reset mid-operation: response SLL 1,3 = 8 pending with rsp_ready=0, assert i_rst one cycle -> o_rsp_valid=0 and result=0. The next tie grants port 0.
6. Throughput: port0 streams EQ 100,100 then NEQ 10,20 back-to-back with rsp_ready=1 -> results 1,1 on consecutive cycles, with no bubble.
